// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter that funnels ALU, register-file and status responses
// into the single TX FIFO write port, one byte per write, LSB byte first.
module tx_resp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_req_i,
    input  logic [ALU_WIDTH-1:0]  alu_data_i,
    input  logic                  rf_req_i,
    input  logic [DATA_WIDTH-1:0] rf_data_i,
    input  logic                  st_req_i,
    input  logic [DATA_WIDTH-1:0] st_data_i,
    input  logic                  fifo_full_i,
    output logic                  alu_ack_o,
    output logic                  rf_ack_o,
    output logic                  st_ack_o,
    output logic [DATA_WIDTH-1:0] tx_p_data_o,
    output logic                  tx_d_vld_o,
    output logic                  busy_o
);

    localparam int HOLD_W   = 2 * DATA_WIDTH;
    localparam bit TWO_BYTE = (ALU_WIDTH == 2 * DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
    typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_RF = 2'd1, SRC_ST = 2'd2} src_t;

    state_t                state_q;
    src_t                  last_q;
    src_t                  gnt_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_vld_q;
    logic                  alu_ack_q;
    logic                  rf_ack_q;
    logic                  st_ack_q;
    logic                  busy_q;

    src_t              grant_d;
    logic [HOLD_W-1:0] payload_d;
    logic              any_req;
    logic              write_ok;

    // Search starts just after the last winner, so a lone requester can win twice in a row.
    always_comb begin
        any_req = alu_req_i | rf_req_i | st_req_i;
        grant_d = SRC_ALU;
        case (last_q)
            SRC_ALU: grant_d = rf_req_i  ? SRC_RF  : (st_req_i  ? SRC_ST  : SRC_ALU);
            SRC_RF:  grant_d = st_req_i  ? SRC_ST  : (alu_req_i ? SRC_ALU : SRC_RF);
            default: grant_d = alu_req_i ? SRC_ALU : (rf_req_i  ? SRC_RF  : SRC_ST);
        endcase

        payload_d = '0;
        case (grant_d)
            SRC_ALU: payload_d = HOLD_W'(alu_data_i);
            SRC_RF:  payload_d = HOLD_W'(rf_data_i);
            default: payload_d = HOLD_W'(st_data_i);
        endcase

        // Never write on consecutive edges so the full flag has settled before each write.
        write_ok = !fifo_full_i && !tx_vld_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_q    <= SRC_ST;
            gnt_q     <= SRC_ALU;
            hold_q    <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            alu_ack_q <= 1'b0;
            rf_ack_q  <= 1'b0;
            st_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            tx_vld_q  <= 1'b0;
            alu_ack_q <= 1'b0;
            rf_ack_q  <= 1'b0;
            st_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q     <= grant_d;
                        last_q    <= grant_d;
                        hold_q    <= payload_d;
                        alu_ack_q <= (grant_d == SRC_ALU);
                        rf_ack_q  <= (grant_d == SRC_RF);
                        st_ack_q  <= (grant_d == SRC_ST);
                        busy_q    <= 1'b1;
                        state_q   <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (write_ok) begin
                        tx_data_q <= hold_q[DATA_WIDTH-1:0];
                        tx_vld_q  <= 1'b1;
                        if (TWO_BYTE && gnt_q == SRC_ALU) begin
                            state_q <= SEND_HI;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                SEND_HI: begin
                    if (write_ok) begin
                        tx_data_q <= hold_q[HOLD_W-1:DATA_WIDTH];
                        tx_vld_q  <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_ack_o   = alu_ack_q;
    assign rf_ack_o    = rf_ack_q;
    assign st_ack_o    = st_ack_q;
    assign tx_p_data_o = tx_data_q;
    assign tx_d_vld_o  = tx_vld_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Scoreboard bench for tx_resp_arbiter: requesters and FIFO-full stimulus feed a
// round-robin reference model; a monitor checks every ACK, write and BUSY level.
module tb_tx_resp_arbiter;

    localparam int DW = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic [AW-1:0] alu_data;
    logic [DW-1:0] rf_data;
    logic [DW-1:0] st_data;
    logic          fifo_full;
    logic          alu_ack, rf_ack, st_ack;
    logic [DW-1:0] tx_data;
    logic          tx_vld;
    logic          busy;

    always #5 clk = ~clk;

    tx_resp_arbiter #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .alu_req_i   (req[0]),
        .alu_data_i  (alu_data),
        .rf_req_i    (req[1]),
        .rf_data_i   (rf_data),
        .st_req_i    (req[2]),
        .st_data_i   (st_data),
        .fifo_full_i (fifo_full),
        .alu_ack_o   (alu_ack),
        .rf_ack_o    (rf_ack),
        .st_ack_o    (st_ack),
        .tx_p_data_o (tx_data),
        .tx_d_vld_o  (tx_vld),
        .busy_o      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: one outstanding request per source, round-robin over (last+1..last+3) mod 3.
    logic [15:0] src_q [3][$];
    bit          pend_v [3];
    logic [15:0] pend_d [3];
    int          cool [3];
    int          req_edge [3];
    int          last_src = 2;
    logic [7:0]  exp_q [$];
    bit          prev_vld = 1'b0;

    int         ack_src [$];
    int         ack_cyc [$];
    logic [7:0] wr_byte [$];
    int         wr_cyc  [$];

    wire [2:0] ack = {st_ack, rf_ack, alu_ack};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int model_pick();
        for (int i = 1; i <= 3; i++) begin
            if (pend_v[(last_src + i) % 3]) return (last_src + i) % 3;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requesters: raise REQ with the next queued payload, drop it once ACK is seen,
    // and stay quiet one more cycle before re-requesting.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (req[i] && ack[i]) begin
                req[i]  = 1'b0;
                cool[i] = 1;
            end else if (!req[i]) begin
                if (cool[i] > 0) begin
                    cool[i]--;
                end else if (src_q[i].size() > 0) begin
                    logic [15:0] d;
                    d = src_q[i].pop_front();
                    case (i)
                        0:       alu_data = d;
                        1:       rf_data  = d[7:0];
                        default: st_data  = d[7:0];
                    endcase
                    req[i]      = 1'b1;
                    pend_v[i]   = 1'b1;
                    pend_d[i]   = d;
                    req_edge[i] = cyc + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_outputs", {26'd0, alu_ack, rf_ack, st_ack, tx_vld, busy, |tx_data}, 32'd0);
            exp_q.delete();
            last_src = 2;
            prev_vld = 1'b0;
        end else begin
            int n;
            int a;
            int w;
            n = int'(alu_ack) + int'(rf_ack) + int'(st_ack);
            if (n > 0) begin
                a = alu_ack ? 0 : (rf_ack ? 1 : 2);
                w = model_pick();
                chk("ack_onehot", n, 1);
                chk("grant_src", a, w);
                ack_src.push_back(a);
                ack_cyc.push_back(cyc);
                if (w >= 0) begin
                    exp_q.push_back(pend_d[w][7:0]);
                    if (w == 0) exp_q.push_back(pend_d[w][15:8]);
                    pend_v[w] = 1'b0;
                    last_src  = w;
                end
            end
            if (tx_vld) begin
                chk("no_write_when_full", fifo_full, 1'b0);
                chk("write_spacing", prev_vld, 1'b0);
                wr_byte.push_back(tx_data);
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h expected no write (cycle %0d)", tx_data, cyc);
                end else begin
                    chk("tx_byte", tx_data, exp_q.pop_front());
                end
            end
            chk("busy", busy, (exp_q.size() != 0));
            prev_vld = tx_vld;
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        ack_src.delete();
        ack_cyc.delete();
        wr_byte.delete();
        wr_cyc.delete();
    endtask

    function automatic bit all_quiet();
        return src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
               req == 3'b000 && exp_q.size() == 0 && !busy &&
               cool[0] == 0 && cool[1] == 0 && cool[2] == 0;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (!all_quiet() && n < budget) begin
            sync();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles expected idle within %0d", name, n, budget);
        end
        repeat (3) sync();
    endtask

    task automatic wait_writes(input int count, input int budget, input string name);
        int n = 0;
        while (wr_byte.size() < count && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: got %0d writes expected %0d", name, wr_byte.size(), count);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) sync();
        rst = 1'b0;
        sync();
    endtask

    initial begin
        rst = 1'b1;
        req = 3'b000;
        alu_data = '0;
        rf_data = '0;
        st_data = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pend_v[i] = 1'b0;
            cool[i] = 0;
            req_edge[i] = 0;
        end
        repeat (3) sync();
        rst = 1'b0;
        sync();

        // RF single byte
        clear_logs();
        src_q[1].push_back(16'h00A5);
        wait_idle(50, "t1");
        chk("t1_ack_count", ack_src.size(), 1);
        chk("t1_write_count", wr_byte.size(), 1);
        if (ack_cyc.size() == 1 && wr_cyc.size() == 1) begin
            chk("t1_ack_edge", ack_cyc[0], req_edge[1]);
            chk("t1_write_edge", wr_cyc[0], ack_cyc[0] + 1);
            chk("t1_byte", wr_byte[0], 8'hA5);
        end

        // ALU two bytes, LSB first, two cycles apart
        clear_logs();
        src_q[0].push_back(16'h1234);
        wait_idle(50, "t2");
        chk("t2_ack_count", ack_src.size(), 1);
        chk("t2_write_count", wr_byte.size(), 2);
        if (wr_byte.size() == 2 && ack_cyc.size() == 1) begin
            chk("t2_lo", wr_byte[0], 8'h34);
            chk("t2_hi", wr_byte[1], 8'h12);
            chk("t2_lo_edge", wr_cyc[0], ack_cyc[0] + 1);
            chk("t2_gap", wr_cyc[1] - wr_cyc[0], 2);
        end

        // Simultaneous requests after reset
        do_reset(2);
        clear_logs();
        src_q[0].push_back(16'h0102);
        src_q[1].push_back(16'h0033);
        src_q[2].push_back(16'h0044);
        wait_idle(100, "t3");
        chk("t3_ack_count", ack_src.size(), 3);
        chk("t3_write_count", wr_byte.size(), 4);
        if (ack_src.size() == 3 && wr_byte.size() == 4) begin
            chk("t3_order", {ack_src[0][7:0], ack_src[1][7:0], ack_src[2][7:0]}, 24'h000102);
            chk("t3_bytes", {wr_byte[0], wr_byte[1], wr_byte[2], wr_byte[3]}, 32'h02013344);
        end

        // FIFO full for 10 cycles between low and high byte
        clear_logs();
        src_q[0].push_back(16'hBEEF);
        wait_writes(1, 50, "t4_lo");
        fifo_full = 1'b1;
        repeat (10) @(negedge clk);
        fifo_full = 1'b0;
        wait_idle(50, "t4");
        chk("t4_write_count", wr_byte.size(), 2);
        if (wr_byte.size() == 2) begin
            chk("t4_bytes", {wr_byte[0], wr_byte[1]}, 16'hEFBE);
            chk("t4_stall_gap", wr_cyc[1] - wr_cyc[0], 11);
        end

        // Reset between low and high byte discards the rest
        clear_logs();
        src_q[0].push_back(16'hCAFE);
        wait_writes(1, 50, "t5_lo");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) sync();
        src_q[2].push_back(16'h005A);
        wait_idle(50, "t5");
        chk("t5_ack_count", ack_src.size(), 2);
        chk("t5_write_count", wr_byte.size(), 2);
        if (wr_byte.size() == 2 && ack_src.size() == 2) begin
            chk("t5_bytes", {wr_byte[0], wr_byte[1]}, 16'hFE5A);
            chk("t5_second_src", ack_src[1], 2);
        end

        // Back-to-back RF
        clear_logs();
        src_q[1].push_back(16'h0011);
        src_q[1].push_back(16'h0022);
        wait_idle(50, "t6");
        chk("t6_ack_count", ack_src.size(), 2);
        chk("t6_write_count", wr_byte.size(), 2);
        if (wr_byte.size() == 2) begin
            chk("t6_bytes", {wr_byte[0], wr_byte[1]}, 16'h1122);
            chk("t6_gap", wr_cyc[1] - wr_cyc[0], 3);
        end

        // Random traffic, FIFO backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            int s;
            if ($urandom_range(0, 2) == 0) begin
                s = $urandom_range(0, 2);
                if (src_q[s].size() < 3)
                    src_q[s].push_back(s == 0 ? 16'($urandom) : {8'h00, 8'($urandom)});
            end
            if ($urandom_range(0, 7) == 0) fifo_full = ~fifo_full;
            rst = ($urandom_range(0, 399) == 0);
            sync();
        end
        rst = 1'b0;
        fifo_full = 1'b0;
        wait_idle(500, "drain");
        chk("final_pending", {29'd0, pend_v[0], pend_v[1], pend_v[2]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_resp_arbiter.md
# tx_resp_arbiter

Shares the single write port of the TX async FIFO between three response sources in the REF_CLK domain: the ALU result, the register-file read data and a status/error byte. Uses round-robin arbitration, captures the winning payload, and serializes it into FIFO writes while respecting the FIFO full flag. Sits between SYS_CTRL's response sources and the FIFO write side (w_data/w_inc).

## Interface
- DATA_WIDTH, 8, FIFO word width; RF_DATA, ST_DATA and TX_P_DATA use this width.
- ALU_WIDTH, 16, ALU result width; legal values are DATA_WIDTH (one byte) or 2*DATA_WIDTH (two bytes).
- CLK  in  1  REF_CLK-domain clock.
- RST  in  1  reset; synchronous, active-high.
- ALU_REQ  in  1  ALU result pending; level, held until ALU_ACK.
- ALU_DATA  in  ALU_WIDTH  ALU result; stable while ALU_REQ is high.
- RF_REQ  in  1  register-file read data pending; level.
- RF_DATA  in  DATA_WIDTH  read data.
- ST_REQ  in  1  status byte pending; level.
- ST_DATA  in  DATA_WIDTH  status byte.
- FIFO_FULL  in  1  async FIFO wfull.
- ALU_ACK / RF_ACK / ST_ACK  out  1  one-cycle grant pulse; payload captured.
- TX_P_DATA  out  DATA_WIDTH  FIFO write data.
- TX_D_VLD  out  1  FIFO write strobe (w_inc), one cycle per byte.
- BUSY  out  1  high while a transaction is held (not IDLE).

## Operation
- States: IDLE, SEND_LO, SEND_HI. All outputs are registered.
- IDLE with at least one REQ high:
  - Grant one requester using round-robin order ALU→RF→ST→ALU, starting after the last granted source.
  - Capture its payload into a holding register.
  - Pulse its ACK for the next cycle.
  - Update the round-robin pointer and go to SEND_LO.
- IDLE with no REQ: stay in IDLE.
- Write-issue condition: FIFO_FULL low AND TX_D_VLD currently low. This guarantees at least one idle cycle between writes, so the registered full flag is always current before the next write.
- SEND_LO:
  - Wait until the write-issue condition holds.
  - Then drive TX_P_DATA = low byte (RF/ST payload, or ALU[DATA_WIDTH-1:0]) and TX_D_VLD = 1.
  - Next state is SEND_HI if the grant is ALU and ALU_WIDTH = 2*DATA_WIDTH; otherwise IDLE.
- SEND_HI: wait for the write-issue condition, issue ALU[2*DATA_WIDTH-1:DATA_WIDTH], go to IDLE.
- Byte order on the wire is LSB byte first.
- TX_D_VLD is cleared on every edge where no write is issued.
- TX_P_DATA holds its last value when TX_D_VLD is low.
- Requester rule: deassert REQ on the edge where ACK is sampled high. The arbiter does not re-sample REQs until it returns to IDLE, which is at least one cycle after ACK.
- REQs that arrive while BUSY stay pending; they are not lost.
- The round-robin pointer advances only on a grant.
- Reset value of the pointer is "last = ST", so ALU has highest priority after reset.
- Reset is dominant. With RST high:
  - state = IDLE, pointer reset, holding register = 0.
  - TX_P_DATA = 0, TX_D_VLD = 0, all ACKs = 0, BUSY = 0.
  - A transaction in progress is discarded: remaining bytes are not sent and ACK is not re-issued.
- FIFO_FULL held high stalls indefinitely in SEND_LO/SEND_HI with BUSY = 1. There is no timeout and no drop.

## Timing
- Req sampled at edge k (state IDLE): grant at edge k, ACK high in cycle k..k+1, BUSY high from k.
- FIFO not full: first TX_D_VLD high in cycle k+1..k+2.
- Single-byte transaction: back in IDLE after edge k+1; earliest next grant at edge k+2, next write at k+3.
- ALU 16-bit: low byte at k+1, TX_D_VLD low at k+2, high byte at k+3, IDLE after k+3.
- Minimum spacing between TX_D_VLD pulses is 2 cycles.
- FIFO_FULL deasserting at edge m (first edge it samples low with TX_D_VLD low) issues the write at edge m.
- Simultaneous REQs on one edge: exactly one ACK; the others are served in round-robin order in later IDLE visits.

## Test plan
- Reset, then RF_REQ with RF_DATA = 0xA5 → RF_ACK pulses 1 cycle after the request edge; next cycle TX_D_VLD = 1 with TX_P_DATA = 0xA5; BUSY returns low.
- ALU_REQ with ALU_DATA = 0x1234 → writes 0x34 then 0x12, 2 cycles apart; exactly one ALU_ACK.
- ALU, RF and ST REQ all high on the same edge after reset (data 0x0102, 0x33, 0x44) → grant order ALU, RF, ST; byte stream 0x02, 0x01, 0x33, 0x44.
- FIFO_FULL held high for 10 cycles during SEND_HI of ALU 0xBEEF → 0xEF written, no write while full, 0xBE written on the first free edge, BUSY stays high throughout.
- RST asserted for 1 cycle between the low and high byte of ALU 0xCAFE → 0xFE only; all outputs 0 the next cycle; a subsequent ST_REQ 0x5A is granted first to ALU if pending, otherwise ST, and is written normally.
- Back-to-back RF_REQ (RF_DATA 0x11, then 0x22) → two ACKs; writes 0x11 and 0x22 with 3-cycle spacing; the pointer moves RF→RF only because no other requester is pending.
